// File: rtl/alu_serial_rx.sv
// rtl/alu_serial_rx.sv - deserialises sin frames into one checked ALU command per packet
// Defining ALU_RX_TIMEOUT_EN adds an inter-frame gap timeout inside a packet.
module alu_serial_rx #(
  parameter int DATA_FRAMES    = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_A,
  output logic [31:0] out_B,
  output logic [2:0]  out_op,
  output logic        out_err,
  output logic [5:0]  out_err_code,
  output logic        overrun,
  output logic        busy
);
  localparam int FCW = $clog2(DATA_FRAMES + 1);

  if (DATA_FRAMES != 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("alu_serial_rx: unsupported parameter values");
  end

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK, S_EVAL} state_t;
  state_t state_q, state_d;

  logic           armed_q, armed_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [9:0]     sh_q, sh_d;
  logic [10:0]    frame_q, frame_d;
  logic [63:0]    ab_q, ab_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           extra_q, extra_d;
  logic           mal_q, mal_d;
  logic [2:0]     op_q, op_d;
  logic [3:0]     crc_q, crc_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;
  logic [31:0]    a_q, a_d, b_q, b_d;
  logic [2:0]     oop_q, oop_d;
  logic [5:0]     code_q, code_d;
  logic           ovr_q, ovr_d;
  logic           tmo_hit;

  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 67; i >= 0; i--) begin
      c = {c[2:0], 1'b0} ^ ((c[3] ^ msg[i]) ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  logic start, frame_end, f_mal, f_cmd, rx_going;
  logic e_data, e_op, e_crc;

  // The deserialiser hunts only once armed, so a line held low through reset is ignored.
  assign start     = armed_q && (bit_cnt_q == 4'd0) && !sin;
  assign frame_end = (bit_cnt_q == 4'd10);
  assign rx_going  = start || (bit_cnt_q != 4'd0);
  assign f_mal     = !frame_q[0] || (frame_q[10] && frame_q[9]) ||
                     (!frame_q[10] && frame_q[9] && frame_q[8]);
  assign f_cmd     = !f_mal && frame_q[9];

  assign e_data = mal_q || extra_q || (fcnt_q != FCW'(DATA_FRAMES));
  assign e_op   = !(op_q == 3'b000 || op_q == 3'b001 || op_q == 3'b100 || op_q == 3'b101);
  assign e_crc  = !e_data && (crc4({ab_q, 1'b1, op_q}) != crc_q);

`ifdef ALU_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] gap_q, gap_d;

  always_comb begin
    gap_d   = gap_q;
    tmo_hit = 1'b0;
    if (start || !busy_q || state_q == S_EVAL) begin
      gap_d = '0;
    end else if (state_q == S_IDLE) begin
      tmo_hit = (gap_q == TW'(TIMEOUT_CYCLES - 1));
      gap_d   = gap_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) gap_q <= '0;
    else       gap_q <= gap_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q | sin;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    frame_d   = frame_q;
    ab_d      = ab_q;
    fcnt_d    = fcnt_q;
    extra_d   = extra_q;
    mal_d     = mal_q;
    op_d      = op_q;
    crc_d     = crc_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    a_d       = a_q;
    b_d       = b_q;
    oop_d     = oop_q;
    code_d    = code_q;
    ovr_d     = 1'b0;

    // Sampling runs independently of the packet FSM so back-to-back frames are not lost.
    if (start) begin
      sh_d      = {sh_q[8:0], sin};
      bit_cnt_d = 4'd1;
      busy_d    = 1'b1;
    end else if (bit_cnt_q != 4'd0) begin
      if (frame_end) begin
        frame_d   = {sh_q, sin};
        bit_cnt_d = 4'd0;
      end else begin
        sh_d      = {sh_q[8:0], sin};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end

    if (valid_q && out_ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
        end else if (tmo_hit) begin
          mal_d   = 1'b1;
          state_d = S_EVAL;
        end
      end
      S_SHIFT: if (frame_end) state_d = S_CHECK;
      S_CHECK: begin
        if (f_mal) begin
          mal_d   = 1'b1;
          state_d = S_EVAL;
        end else if (f_cmd) begin
          op_d    = frame_q[7:5];
          crc_d   = frame_q[4:1];
          state_d = S_EVAL;
        end else begin
          if (fcnt_q < FCW'(DATA_FRAMES)) begin
            ab_d   = {ab_q[55:0], frame_q[8:1]};
            fcnt_d = fcnt_q + 1'b1;
          end else begin
            extra_d = 1'b1;
          end
          state_d = rx_going ? S_SHIFT : S_IDLE;
        end
      end
      S_EVAL: begin
        if (!valid_q || out_ready) begin
          valid_d = 1'b1;
          a_d     = ab_q[31:0];
          b_d     = ab_q[63:32];
          oop_d   = op_q;
          code_d  = {e_data, e_crc, e_op, e_data, e_crc, e_op};
        end else begin
          ovr_d = 1'b1;
        end
        ab_d    = '0;
        fcnt_d  = '0;
        extra_d = 1'b0;
        mal_d   = 1'b0;
        op_d    = '0;
        crc_d   = '0;
        busy_d  = rx_going;
        state_d = rx_going ? S_SHIFT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      frame_q   <= '0;
      ab_q      <= '0;
      fcnt_q    <= '0;
      extra_q   <= 1'b0;
      mal_q     <= 1'b0;
      op_q      <= '0;
      crc_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      oop_q     <= '0;
      code_q    <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      frame_q   <= frame_d;
      ab_q      <= ab_d;
      fcnt_q    <= fcnt_d;
      extra_q   <= extra_d;
      mal_q     <= mal_d;
      op_q      <= op_d;
      crc_q     <= crc_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      a_q       <= a_d;
      b_q       <= b_d;
      oop_q     <= oop_d;
      code_q    <= code_d;
      ovr_q     <= ovr_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_A        = a_q;
  assign out_B        = b_q;
  assign out_op       = oop_q;
  assign out_err_code = code_q;
  assign out_err      = |code_q;
  assign overrun      = ovr_q;
  assign busy         = busy_q;
endmodule

// File: doc/alu_serial_rx.md
Name: alu_serial_rx

Overview:
- Serial command receiver at the ALU input; consumes the `sin` frame stream the ALU driver produces.
- Deserialises 11-bit frames (8 data frames plus 1 command frame), reassembles the operands, and checks frame format, operand count, opcode and CRC.
- Presents one decoded command per packet to the ALU core through a valid/ready register stage.

Parameters:
- DATA_FRAMES, 8, number of data frames required per packet (B MSB byte first, then A).
- TIMEOUT_CYCLES, 64, maximum idle gap between frames inside one packet (used only with the optional feature).

Ports:
- clk  in  1  clock; `sin` is sampled on posedge.
- rst_n  in  1  synchronous reset, active-high: asserted = 1.
- sin  in  1  serial line; idles high.
- out_ready  in  1  core accepts the command.
- out_valid  out  1  decoded command available.
- out_A  out  32  operand A.
- out_B  out  32  operand B.
- out_op  out  3  opcode.
- out_err  out  1  packet rejected.
- out_err_code  out  6  {data,crc,op,data,crc,op} error flags.
- overrun  out  1  one-cycle pulse: a completed packet was dropped.
- busy  out  1  a packet is in progress.

Behaviour:
- Interface: one clock (`clk`); reset (`rst_n`) is synchronous and active-high.
- Frame format, bits b10..b0, first received first:
  - Data frame = 0,0,byte[7:0],1.
  - Command frame = 0,1,0,op[2:0],crc[3:0],1.
  - Frames may arrive back-to-back or with idle-high gaps.
- State machine:
  - IDLE → SHIFT when `sin`=0 is sampled; that sample is b10.
  - SHIFT samples 11 bits, counter 0..10, then → CHECK.
  - CHECK classifies the frame in one cycle. Data frame: shift byte into the 64-bit {B,A} register, frame count +1, → IDLE. Command frame → EVAL. Malformed frame → EVAL with ERR_DATA set.
  - EVAL loads the output registers in one cycle, clears the packet state, → IDLE.
- Malformed frame means any of: stop bit 0; b10..b9 = 1,1; b10..b8 = 0,1,1.
- ERR_DATA is also set if the data-frame count ≠ DATA_FRAMES at command time, or if a 9th data frame arrives (flagged at the command frame; extra bytes ignored).
- ERR_OP: op is not one of AND=000, OR=001, ADD=100, SUB=101.
- ERR_CRC checks the received crc against CRC-4:
  - Polynomial x^4+x+1, init 0, processed MSB-first.
  - Message is the 68 bits {B,A,1'b1,op}.
  - Not evaluated when ERR_DATA is set.
- Error precedence is not exclusive; all applicable flags are set. out_err = OR of the flags.
- On error, out_A/out_B/out_op still load the received values; unreceived bytes are 0.
- Latency: command stop bit sampled at edge N → CHECK at N+1 → out_valid=1 after edge N+2.
- Output handshake:
  - Outputs are held stable while out_valid && !out_ready.
  - out_valid drops the cycle after a cycle with out_valid && out_ready.
  - Reception continues while output is held.
  - If EVAL occurs while out_valid is held: the new packet is dropped, overrun=1 for one cycle, outputs unchanged.
  - If EVAL coincides with a handshake cycle, the new packet loads with no overrun.
- busy = 1 from the first data-frame start bit until EVAL.
- Reset values: all outputs 0, state IDLE, frame count 0, shift register 0.
- Reset mid-frame or mid-packet: the partial packet is discarded.
- After reset release, `sin` must be sampled high at least once before the start-bit hunt, so a stream low at release gives no false start.

Optional Feature:
- Macro: ALU_RX_TIMEOUT_EN.
- Defined:
  - Inter-frame gap counter runs in IDLE while busy=1.
  - Reaching TIMEOUT_CYCLES with no start bit forces EVAL with ERR_DATA; the packet is reported as an error.
  - Counter resets on every start bit.
- Undefined: the receiver waits indefinitely between frames and the counter logic is absent.

Test Plan:
- Clean packet: A=1, B=2, ADD, correct crc, out_ready=1 → out_valid=1 for exactly one cycle, 2 edges after the stop bit; out_A=1, out_B=2, out_op=100, out_err=0, out_err_code=000000.
- Corrupt crc: A=32'hFFFF_FFFF, B=5, AND, crc XOR 4'b0001 → out_err=1, out_err_code=010010, out_A=32'hFFFF_FFFF.
- Short packet: 7 data frames then command → out_err=1, out_err_code=100100. Invalid op 010 with correct crc → out_err_code=001001.
- Backpressure: out_ready=0, two clean packets back-to-back → first held unchanged, overrun pulses once at the second EVAL; out_ready=1 → one handshake, out_valid=0 next cycle.
- Reset mid-packet: rst_n=1 for one cycle during the 5th data frame → all outputs 0, busy=0; next clean packet A=7, B=-3, SUB decodes with out_err=0.
- With ALU_RX_TIMEOUT_EN: 3 data frames, then `sin` high for TIMEOUT_CYCLES → out_err=1, out_err_code=100100, busy=0. Without the macro, the same stimulus gives no output.
